// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO display arbiter.
package pio_arb_pkg;

    typedef enum logic {
        OWN_LOCAL = 1'b0,
        OWN_HOST  = 1'b1
    } owner_e;

    localparam int unsigned WALK_W     = 18;
    localparam logic [31:0]  LEDG_LOCAL = 32'h0000_00FF;
    localparam logic [WALK_W-1:0] WALK_RESET = WALK_W'(1);

    // One snapshot of all four display words.
    typedef struct packed {
        logic [31:0] hex;
        logic [31:0] hexl;
        logic [31:0] ledg;
        logic [31:0] ledr;
    } disp_words_t;

endpackage

// File: rtl/local_pattern_gen.sv
// Free-running self-test pattern: a step counter and a one-hot walker that
// both advance once every PATTERN_DIV cycles.
// Ports: CLOCK_50 clock, reset async active-high, step 32-bit count,
//        walk 18-bit one-hot rotating left.
module local_pattern_gen
    import pio_arb_pkg::*;
#(
    parameter int unsigned PATTERN_DIV = 12_500_000,
    parameter logic [31:0] STEP_RESET  = 32'h0000_0000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    output logic [31:0]       step,
    output logic [WALK_W-1:0] walk
);

    localparam int unsigned DIV_W = (PATTERN_DIV > 1) ? $clog2(PATTERN_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_W'(PATTERN_DIV - 1));

    // Divider, step counter and walker advance together at divider wrap.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            step    <= STEP_RESET;
            walk    <= WALK_RESET;
        end else if (wrap) begin
            div_cnt <= '0;
            step    <= step + 32'd1;
            walk    <= {walk[WALK_W-2:0], walk[WALK_W-1]};
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pio_display_arbiter.sv
// Arbitrates the board display words between host PIO writes and the local
// self-test pattern. Any changed host word hands ownership to the host; an
// idle timeout or force_local hands it back.
// Ports: CLOCK_50 clock, reset async active-high, host_* 32-bit PIO words,
//        force_local level override, *_out registered display words,
//        owner_host current owner, timeout_pulse one cycle on timeout revert.
module pio_display_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned PATTERN_DIV    = 12_500_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] host_hex,
    input  logic [31:0] host_hexl,
    input  logic [31:0] host_ledg,
    input  logic [31:0] host_ledr,
    input  logic        force_local,
    output logic [31:0] hex_out,
    output logic [31:0] hexl_out,
    output logic [31:0] ledg_out,
    output logic [31:0] ledr_out,
    output logic        owner_host,
    output logic        timeout_pulse
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

    disp_words_t       s1, s2, out_q, out_n, local_words;
    owner_e            state_q, state_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic              activity;
    logic              timeout_c;
    logic [31:0]       step;
    logic [WALK_W-1:0] walk;

    local_pattern_gen #(
        .PATTERN_DIV (PATTERN_DIV)
    ) u_pattern (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .step     (step),
        .walk     (walk)
    );

    // Two-stage input capture; a difference between stages is host activity.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= '{hex: host_hex, hexl: host_hexl, ledg: host_ledg, ledr: host_ledr};
            s2 <= s1;
        end
    end

    assign activity    = (s1 != s2);
    assign local_words = '{hex: step, hexl: 32'h0, ledg: LEDG_LOCAL, ledr: 32'(walk)};

    // Ownership next-state, idle counter and output selection.
    always_comb begin
        state_n   = state_q;
        timeout_c = 1'b0;
        idle_n    = '0;
        out_n     = local_words;
        case (state_q)
            OWN_LOCAL: begin
                if (activity && !force_local) begin
                    state_n = OWN_HOST;
                end
            end
            OWN_HOST: begin
                if (force_local) begin
                    state_n = OWN_LOCAL;
                end else if (!activity && idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = OWN_LOCAL;
                    timeout_c = 1'b1;
                end
            end
            default: state_n = OWN_LOCAL;
        endcase
        // Count only while staying in HOST with a quiet input stage.
        if (state_q == OWN_HOST && state_n == OWN_HOST && !activity) begin
            idle_n = idle_cnt + IDLE_W'(1);
        end
        if (state_n == OWN_HOST) begin
            out_n = s1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= OWN_LOCAL;
            idle_cnt      <= '0;
            out_q         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_n;
            idle_cnt      <= idle_n;
            out_q         <= out_n;
            timeout_pulse <= timeout_c;
        end
    end

    assign owner_host = (state_q == OWN_HOST);
    assign hex_out    = out_q.hex;
    assign hexl_out   = out_q.hexl;
    assign ledg_out   = out_q.ledg;
    assign ledr_out   = out_q.ledr;

endmodule

// File: tb/tb_pio_display_arbiter.sv
// Directed bench for pio_display_arbiter: reset, host takeover, timeout,
// timeout/activity collision, force_local, pattern walk and step wrap.
module tb_pio_display_arbiter;

    localparam int unsigned T_CYC = 16;
    localparam int unsigned PD    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_hex, host_hexl, host_ledg, host_ledr;
    logic        force_local;
    logic [31:0] hex_out, hexl_out, ledg_out, ledr_out;
    logic        owner_host, timeout_pulse;
    logic [31:0] pw_step;
    logic [17:0] pw_walk;

    int n_chk  = 0;
    int n_pass = 0;
    int ecyc   = 0;

    always #5 clk = ~clk;

    pio_display_arbiter #(
        .TIMEOUT_CYCLES (T_CYC),
        .PATTERN_DIV    (PD)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .host_hex      (host_hex),
        .host_hexl     (host_hexl),
        .host_ledg     (host_ledg),
        .host_ledr     (host_ledr),
        .force_local   (force_local),
        .hex_out       (hex_out),
        .hexl_out      (hexl_out),
        .ledg_out      (ledg_out),
        .ledr_out      (ledr_out),
        .owner_host    (owner_host),
        .timeout_pulse (timeout_pulse)
    );

    // Pattern generator preloaded near the step wrap point, divider of 1.
    local_pattern_gen #(
        .PATTERN_DIV (1),
        .STEP_RESET  (32'hFFFF_FFFD)
    ) u_pw (
        .CLOCK_50 (clk),
        .reset    (rst),
        .step     (pw_step),
        .walk     (pw_walk)
    );

    typedef struct {
        logic [31:0] hex;
        logic [31:0] hexl;
        logic [31:0] ledg;
        logic [31:0] ledr;
        logic        frc;
        int          cyc;
        logic        own;
        logic        pls;
        int          mode;  // 0 = skip words, 1 = host words, 2 = local pattern
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecyc);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ecyc++;
        end
    endtask

    // Output pattern visible after edge e reflects the generator state after edge e-1.
    function automatic logic [31:0] m_step(input int e);
        return 32'((e - 1) / int'(PD));
    endfunction

    function automatic logic [31:0] m_ledr(input int e);
        int idx;
        logic [31:0] one;
        idx = ((e - 1) / int'(PD)) % 18;
        one = 32'h1;
        return one << idx;
    endfunction

    task automatic chk_pattern(input string tag);
        chk({tag, "_hex"},  hex_out,  m_step(ecyc));
        chk({tag, "_hexl"}, hexl_out, 32'h0);
        chk({tag, "_ledg"}, ledg_out, 32'h0000_00FF);
        chk({tag, "_ledr"}, ledr_out, m_ledr(ecyc));
    endtask

    initial begin
        rst = 1'b1;
        host_hex = '0; host_hexl = '0; host_ledg = '0; host_ledr = '0;
        force_local = 1'b0;

        //           hex           hexl   ledg        ledr        frc cyc own pls mode
        tv[0]  = '{32'h1234_5678, 32'h0, 32'h0,      32'h5A5A,  1'b0, 1,  1'b0, 1'b0, 2};
        tv[1]  = '{32'h1234_5678, 32'h0, 32'h0,      32'h5A5A,  1'b0, 1,  1'b1, 1'b0, 1};
        tv[2]  = '{32'h1234_5678, 32'h0, 32'h0,      32'h5A5A,  1'b0, 15, 1'b1, 1'b0, 1};
        tv[3]  = '{32'h1234_5678, 32'h0, 32'h0,      32'h5A5A,  1'b0, 1,  1'b0, 1'b1, 2};
        tv[4]  = '{32'h1234_5678, 32'h0, 32'h0,      32'h5A5A,  1'b0, 1,  1'b0, 1'b0, 2};
        tv[5]  = '{32'h1234_5678, 32'h1, 32'h0,      32'h5A5A,  1'b0, 2,  1'b1, 1'b0, 1};
        tv[6]  = '{32'h1234_5678, 32'h1, 32'h0,      32'h5A5A,  1'b0, 14, 1'b1, 1'b0, 1};
        tv[7]  = '{32'h1234_5678, 32'h2, 32'h0,      32'h5A5A,  1'b0, 1,  1'b1, 1'b0, 0};
        tv[8]  = '{32'h1234_5678, 32'h2, 32'h0,      32'h5A5A,  1'b0, 1,  1'b1, 1'b0, 1};
        tv[9]  = '{32'h1234_5678, 32'h2, 32'h0,      32'h5A5A,  1'b0, 15, 1'b1, 1'b0, 1};
        tv[10] = '{32'h1234_5678, 32'h2, 32'h0,      32'h5A5A,  1'b0, 1,  1'b0, 1'b1, 2};
        tv[11] = '{32'h1234_5678, 32'h2, 32'hABCD,   32'h5A5A,  1'b0, 2,  1'b1, 1'b0, 1};
        tv[12] = '{32'h1234_5678, 32'h2, 32'hABCD,   32'h5A5A,  1'b0, 3,  1'b1, 1'b0, 1};
        tv[13] = '{32'hCAFE_F00D, 32'h2, 32'hABCD,   32'h5A5A,  1'b1, 1,  1'b0, 1'b0, 2};
        tv[14] = '{32'hCAFE_F00D, 32'h2, 32'hABCD,   32'h5A5A,  1'b1, 4,  1'b0, 1'b0, 2};
        tv[15] = '{32'hCAFE_F00D, 32'h2, 32'hABCD,   32'h5A5A,  1'b0, 4,  1'b0, 1'b0, 2};
        tv[16] = '{32'hCAFE_F00D, 32'h2, 32'hABCD,   32'h5A5A,  1'b0, 3,  1'b0, 1'b0, 2};
        tv[17] = '{32'hCAFE_F00D, 32'h2, 32'hABCD,   32'h1,     1'b0, 2,  1'b1, 1'b0, 1};

        // Reset held for three edges: everything quiet.
        tick(3);
        chk("rst_hex",   hex_out,  32'h0);
        chk("rst_hexl",  hexl_out, 32'h0);
        chk("rst_ledg",  ledg_out, 32'h0);
        chk("rst_ledr",  ledr_out, 32'h0);
        chk("rst_owner", 32'(owner_host),    32'h0);
        chk("rst_pulse", 32'(timeout_pulse), 32'h0);
        chk("rst_pw_step", pw_step, 32'hFFFF_FFFD);

        rst  = 1'b0;
        ecyc = 0;
        tick(1);
        chk("rel_hex",   hex_out,  32'h0);
        chk("rel_ledg",  ledg_out, 32'h0000_00FF);
        chk("rel_ledr",  ledr_out, 32'h1);
        chk("rel_owner", 32'(owner_host), 32'h0);
        chk("pw_step_e1", pw_step, 32'hFFFF_FFFE);
        tick(1);
        chk("pw_step_e2", pw_step, 32'hFFFF_FFFF);
        tick(1);
        chk("pw_step_wrap", pw_step, 32'h0);
        chk("pw_walk_e3", 32'(pw_walk), 32'h8);
        tick(2);
        chk("pat_hex_step1",  hex_out,  32'h1);
        chk("pat_ledr_step1", ledr_out, 32'h2);

        // Table-driven ownership scenarios.
        for (int v = 0; v < 18; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            host_hex    = tv[v].hex;
            host_hexl   = tv[v].hexl;
            host_ledg   = tv[v].ledg;
            host_ledr   = tv[v].ledr;
            force_local = tv[v].frc;
            tick(tv[v].cyc);
            chk({tag, "_owner"}, 32'(owner_host),    32'(tv[v].own));
            chk({tag, "_pulse"}, 32'(timeout_pulse), 32'(tv[v].pls));
            if (tv[v].mode == 1) begin
                chk({tag, "_hex"},  hex_out,  tv[v].hex);
                chk({tag, "_hexl"}, hexl_out, tv[v].hexl);
                chk({tag, "_ledg"}, ledg_out, tv[v].ledg);
                chk({tag, "_ledr"}, ledr_out, tv[v].ledr);
            end else if (tv[v].mode == 2) begin
                chk_pattern(tag);
            end
        end

        // Pattern free-runs through a full walk cycle while held local.
        force_local = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            chk("walk_owner", 32'(owner_host), 32'h0);
            chk("walk_hex",   hex_out,  m_step(ecyc));
            chk("walk_ledr",  ledr_out, m_ledr(ecyc));
            if ((((ecyc - 1) / int'(PD)) % 18) == 0)
                chk("walk_wrap", ledr_out, 32'h1);
        end
        force_local = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pio_display_arbiter.md
# pio_display_arbiter

Arbitrates ownership of the board display resources (hex, hex-low, green LEDs, red LEDs) between the host-written PCIe PIO output ports and a local self-test pattern. Sits between the PCIe core's PIO exports and the board pin drivers. The host takes ownership on any write that changes a value; ownership reverts to the local pattern after a programmable idle timeout or when a force input is asserted.

## Interface
- TIMEOUT_CYCLES, 50_000_000: idle cycles in HOST before reverting to LOCAL (1 s at 50 MHz); must be ≥ 2.
- PATTERN_DIV, 12_500_000: cycles per local-pattern step; must be ≥ 1.
- CLOCK_50  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- host_hex  in  32  from hexport export.
- host_hexl  in  32  from hexlport export.
- host_ledg  in  32  from ledsgreenport export.
- host_ledr  in  32  from ledsredport export.
- force_local  in  1  level; while high, owner is LOCAL; synchronous to CLOCK_50.
- hex_out, hexl_out, ledg_out, ledr_out  out  32 each  registered values to board drivers.
- owner_host  out  1  1 = HOST owns outputs, 0 = LOCAL.
- timeout_pulse  out  1  one-cycle pulse on HOST→LOCAL transition caused by timeout.

## Operation
- Input stage: all four host words registered into s1 every cycle; s1 copied into s2 every cycle. activity = (s1 != s2) over all 128 bits.
- FSM, two states. LOCAL (reset state) and HOST.
  - LOCAL → HOST: activity && !force_local.
  - HOST → LOCAL: force_local (no timeout_pulse), or idle_cnt == TIMEOUT_CYCLES−1 && !activity (timeout_pulse = 1).
  - Otherwise hold.
- idle_cnt, width $clog2(TIMEOUT_CYCLES): cleared on activity, on entry to HOST, and in LOCAL; increments in HOST otherwise; saturation is not reachable.
- Local pattern (sub-module): div_cnt counts 0..PATTERN_DIV−1; at wrap, step increments.
  - step: 32-bit, wraps 0xFFFFFFFF→0.
  - walk: 18-bit one-hot rotating left, bit 17→bit 0; reset value 18'h00001.
- Output mux (registered) selected by the next-state owner:
  - HOST: outputs = s1 words.
  - LOCAL: hex_out = step, hexl_out = 0, ledg_out = 32'h0000_00FF, ledr_out = {14'b0, walk}.
- Pattern runs continuously in both states; it does not restart on ownership change.
- Boundaries:
  - activity in the same cycle the timeout would fire → activity wins, stay HOST, idle_cnt = 0.
  - force_local and activity together → LOCAL.
  - Release of force_local does not return to HOST; a new change is required.
  - Host rewriting an identical value is not activity.
- Reset, asserted at any time: all outputs 0, owner_host 0, timeout_pulse 0, s1/s2 0, idle_cnt/div_cnt/step 0, walk 18'h00001. The first cycle after reset release drives the LOCAL pattern.

## Timing
- A host word change sampled at edge k appears in s1. activity is high during cycle k..k+1. The FSM enters HOST at edge k+1, and hex/led outputs show the new value at edge k+1 (2 edges of latency from input change to pin).
- In HOST, further changes propagate with the same 2-edge latency.
- Timeout: TIMEOUT_CYCLES edges after the last activity cycle, owner_host falls. Outputs show the pattern on that same edge, with timeout_pulse high for exactly that one cycle.
- force_local rising, sampled at edge j: owner_host = 0 and pattern on outputs at edge j.

## Structure
- Shared package pio_arb_pkg: owner_e enum {OWN_LOCAL, OWN_HOST}, LEDG_LOCAL = 32'h0000_00FF, WALK_W = 18, WALK_RESET.
- Sub-module local_pattern_gen (div_cnt, step, walk) with ports CLOCK_50, reset, step, walk.
- Top module holds the input registers, activity compare, FSM, idle counter and output registers.

## Test plan
(TIMEOUT_CYCLES = 16, PATTERN_DIV = 4 unless noted.)
- Reset → hold 3 cycles, release: all outputs 0 during reset; after release ledg_out = 0xFF, ledr_out = 1, owner_host = 0; ledr_out = 2 after 4 cycles, hex_out = 1.
- Host writes host_ledr = 0x5A5A → owner_host = 1 and ledr_out = 0x5A5A two edges after the change; hex_out = host_hex.
- No host change for 16 cycles after the last activity → owner_host 1→0, timeout_pulse high for exactly 1 cycle, outputs show the current pattern.
- Host change lands on the cycle idle_cnt = 15 → stays HOST, no timeout_pulse, a new 16-cycle window starts.
- force_local pulsed for 5 cycles while in HOST, together with a host change → LOCAL immediately, no timeout_pulse. After release, stays LOCAL until the next distinct host write.
- Walk wraparound: run 18 steps (72 cycles) → ledr_out returns to 0x00001. Preload step near 0xFFFFFFFF (PATTERN_DIV = 1) → wraps to 0.
